// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode/immediate words from program memory,
// issues each instruction to the processor and waits for its completion.
module fetch_unit #(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_data,
   output logic [8:0]        ir,
   output logic [15:0]       din,
   output logic              run,
   input  logic              done,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instr_count
);

   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
   localparam logic [2:0]        OP_MVI   = 3'b001;
   localparam logic [2:0]        OP_HALT  = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_I,
      LOAD_I,
      FETCH_D,
      LOAD_D,
      ISSUE,
      WAIT_DONE,
      HALT
   } state_t;

   state_t state, state_nxt;

   logic ld_ir;
   logic ld_din;
   logic inc_pc;
   logic inc_cnt;
   logic restart;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (&v) return v;
      return v + 16'd1;
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      run       = 1'b0;
      ld_ir     = 1'b0;
      ld_din    = 1'b0;
      inc_pc    = 1'b0;
      inc_cnt   = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH_I;
         end
         FETCH_I: begin
            mem_rd    = 1'b1;
            state_nxt = LOAD_I;
         end
         LOAD_I: begin
            // A HALT word leaves ir and pc untouched so pc keeps pointing at it.
            if (mem_data[8:6] == OP_HALT) begin
               state_nxt = HALT;
            end else begin
               ld_ir     = 1'b1;
               inc_pc    = 1'b1;
               state_nxt = (mem_data[8:6] == OP_MVI) ? FETCH_D : ISSUE;
            end
         end
         FETCH_D: begin
            mem_rd    = 1'b1;
            state_nxt = LOAD_D;
         end
         LOAD_D: begin
            ld_din    = 1'b1;
            inc_pc    = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: begin
            run       = 1'b1;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done) begin
               inc_cnt   = 1'b1;
               state_nxt = FETCH_I;
            end
         end
         HALT: begin
            if (start) begin
               restart   = 1'b1;
               state_nxt = FETCH_I;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc          <= START_PC;
         ir          <= '0;
         din         <= '0;
         instr_count <= '0;
      end else begin
         if (restart) begin
            pc          <= START_PC;
            instr_count <= '0;
         end else begin
            if (inc_pc)  pc          <= pc + ADDR_W'(1);
            if (inc_cnt) instr_count <= sat_inc(instr_count);
         end
         if (ld_ir)  ir  <= mem_data[8:0];
         if (ld_din) din <= mem_data;
      end
   end

   assign mem_addr = pc;
   assign busy     = (state != IDLE) && (state != HALT);
   assign halted   = (state == HALT);

endmodule
